// File: rtl/s_axil_reg_bank.sv
// s_axil_reg_bank: AXI4-Lite slave register file.
//   NUM_CTRL read/write control words (byte strobes, per-word commit pulse),
//   NUM_STAT read-only status words, SLVERR for writes to status words,
//   DECERR for unmapped accesses.
// Optional build macro: AXIL_REG_SNAPSHOT_EN -- a read of status word 0
//   captures every status input into a shadow; other status reads return it.
// Ports:
//   axi_clock, rst      : clock, synchronous active-high reset
//   s_axil_aw*/w*/b*    : write address / data / response channels
//   s_axil_ar*/r*       : read address / data channels
//   ctrl_regs           : control words, word i at [32*i+:32]
//   ctrl_we             : one-cycle pulse when word i is committed
//   status_regs         : status inputs, word j at [32*j+:32]
module s_axil_reg_bank #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 8,
    parameter int          NUM_CTRL    = 8,
    parameter int          NUM_STAT    = 4,
    parameter logic [31:0] RESET_VAL   = 32'h0,
    parameter logic [31:0] DECERR_DATA = 32'hDEADBEEF
) (
    input  logic                       axi_clock,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [DATA_WIDTH-1:0]      s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]    s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [DATA_WIDTH-1:0]      s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [NUM_CTRL*32-1:0]     ctrl_regs,
    output logic [NUM_CTRL-1:0]        ctrl_we,
    input  logic [NUM_STAT*32-1:0]     status_regs
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int CW    = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
    localparam int SW    = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    logic [31:0] ctrl_q [NUM_CTRL];
    logic [31:0] stat_w [NUM_STAT];

    for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl
        assign ctrl_regs[32*i +: 32] = ctrl_q[i];
    end
    for (genvar j = 0; j < NUM_STAT; j++) begin : g_stat
        assign stat_w[j] = status_regs[32*j +: 32];
    end

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // ---------------- write path ----------------
    wstate_t          wstate;
    logic             aw_held, w_held;
    logic [IDX_W-1:0] aw_idx;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic          wr_is_ctrl, wr_is_stat;
    logic [CW-1:0] wr_cidx;
    assign wr_is_ctrl = 32'(aw_idx) < NUM_CTRL;
    assign wr_is_stat = !wr_is_ctrl && (32'(aw_idx) < NUM_CTRL + NUM_STAT);
    assign wr_cidx    = CW'(aw_idx);

    always_ff @(posedge axi_clock) begin
        if (rst) begin
            wstate         <= W_IDLE;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_idx         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= 2'b00;
            ctrl_we        <= '0;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= RESET_VAL;
        end else begin
            ctrl_we <= '0;
            case (wstate)
                W_IDLE: begin
                    if (s_axil_awvalid && s_axil_awready) begin
                        aw_idx         <= s_axil_awaddr[ADDR_WIDTH-1:2];
                        aw_held        <= 1'b1;
                        s_axil_awready <= 1'b0;
                    end
                    if (s_axil_wvalid && s_axil_wready) begin
                        wdata_q       <= s_axil_wdata;
                        wstrb_q       <= s_axil_wstrb;
                        w_held        <= 1'b1;
                        s_axil_wready <= 1'b0;
                    end
                    // Both readies are already low here, so no new capture races the commit.
                    if (aw_held && w_held) begin
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axil_bvalid <= 1'b1;
                        wstate        <= W_RESP;
                        if (wr_is_ctrl) begin
                            for (int b = 0; b < 4; b++)
                                if (wstrb_q[b]) ctrl_q[wr_cidx][8*b +: 8] <= wdata_q[8*b +: 8];
                            ctrl_we[wr_cidx] <= 1'b1;
                            s_axil_bresp     <= 2'b00;
                        end else if (wr_is_stat) begin
                            s_axil_bresp <= 2'b10;
                        end else begin
                            s_axil_bresp <= 2'b11;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        s_axil_bvalid  <= 1'b0;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                        wstate         <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    rstate_t          rstate;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_is_ctrl, rd_is_stat;
    logic [CW-1:0]    rd_cidx;
    logic [SW-1:0]    rd_sidx;
    assign rd_idx     = s_axil_araddr[ADDR_WIDTH-1:2];
    assign rd_is_ctrl = 32'(rd_idx) < NUM_CTRL;
    assign rd_is_stat = !rd_is_ctrl && (32'(rd_idx) < NUM_CTRL + NUM_STAT);
    assign rd_cidx    = CW'(rd_idx);
    assign rd_sidx    = SW'(rd_idx - IDX_W'(NUM_CTRL));

`ifdef AXIL_REG_SNAPSHOT_EN
    logic [31:0] shadow_q [NUM_STAT];
`endif

    always_ff @(posedge axi_clock) begin
        if (rst) begin
            rstate         <= R_IDLE;
            s_axil_arready <= 1'b1;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= 2'b00;
`ifdef AXIL_REG_SNAPSHOT_EN
            for (int j = 0; j < NUM_STAT; j++) shadow_q[j] <= '0;
`endif
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s_axil_arvalid && s_axil_arready) begin
                        s_axil_arready <= 1'b0;
                        s_axil_rvalid  <= 1'b1;
                        rstate         <= R_RESP;
                        if (rd_is_ctrl) begin
                            // Sees the pre-commit value if a write lands on this edge.
                            s_axil_rdata <= ctrl_q[rd_cidx];
                            s_axil_rresp <= 2'b00;
                        end else if (rd_is_stat) begin
`ifdef AXIL_REG_SNAPSHOT_EN
                            if (rd_sidx == '0) begin
                                for (int j = 0; j < NUM_STAT; j++) shadow_q[j] <= stat_w[j];
                                s_axil_rdata <= stat_w[0];
                            end else begin
                                s_axil_rdata <= shadow_q[rd_sidx];
                            end
`else
                            s_axil_rdata <= stat_w[rd_sidx];
`endif
                            s_axil_rresp <= 2'b00;
                        end else begin
                            s_axil_rdata <= DECERR_DATA;
                            s_axil_rresp <= 2'b11;
                        end
                    end
                end
                R_RESP: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid  <= 1'b0;
                        s_axil_arready <= 1'b1;
                        rstate         <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_s_axil_reg_bank.sv
// tb_s_axil_reg_bank: directed self-checking bench for s_axil_reg_bank
// (default parameters: 8 control words, 4 status words, RESET_VAL=0).
module tb_s_axil_reg_bank;
    logic         axi_clock = 1'b0;
    logic         rst;
    logic [7:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] ctrl_regs;
    logic [7:0]   ctrl_we;
    logic [127:0] status_regs;

    int checks = 0;
    int failures = 0;
    int we_count = 0;

    always #5 axi_clock = ~axi_clock;
    always @(posedge axi_clock) we_count <= we_count + $countones(ctrl_we);

    s_axil_reg_bank dut (
        .axi_clock(axi_clock), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .ctrl_regs(ctrl_regs), .ctrl_we(ctrl_we), .status_regs(status_regs)
    );

    task automatic tick();
        @(posedge axi_clock); #1;
    endtask

    // Full write transaction; ok=0 if a channel never handshakes.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit ok);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready; w_hs = wvalid && wready;
            tick();
            if (aw_hs) begin aw_done = 1; awvalid = 0; end
            if (w_hs)  begin w_done = 1;  wvalid = 0; end
            n++;
        end
        awvalid = 0; wvalid = 0; bready = 1; n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        ok = bvalid && aw_done && w_done; resp = bresp;
        tick(); bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output bit ok);
        bit hs = 0, hs_now;
        int n = 0;
        araddr = a; arvalid = 1;
        while (!hs && n < 50) begin
            hs_now = arready; tick(); hs = hs_now; n++;
        end
        arvalid = 0; rready = 1; n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        ok = rvalid && hs; d = rdata; resp = rresp;
        tick(); rready = 0;
    endtask

    task automatic test_reset();
        rst = 1; repeat (3) tick(); rst = 0;
        checks++; if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b exp=111", {awready, wready, arready}); end
        checks++; if ({bvalid, rvalid} !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", {bvalid, rvalid}); end
        checks++; if (ctrl_regs !== 256'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_regs); end
        checks++; if ({ctrl_we, bresp, rresp, rdata} !== 44'h0) begin failures++; $display("FAIL reset_misc got=%h exp=0", {ctrl_we, bresp, rresp, rdata}); end
    endtask

    task automatic test_write_aligned();
        logic [31:0] d; logic [1:0] r; bit ok;
        awaddr = 8'h08; wdata = 32'hA5A5_1234; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick(); awvalid = 0; wvalid = 0;
        checks++; if ({bvalid, ctrl_we} !== 9'h0) begin failures++; $display("FAIL wr_early got=%h exp=0", {bvalid, ctrl_we}); end
        tick();
        checks++; if (ctrl_regs[95:64] !== 32'hA5A5_1234) begin failures++; $display("FAIL wr_word2 got=%h exp=a5a51234", ctrl_regs[95:64]); end
        checks++; if (ctrl_we !== 8'b0000_0100) begin failures++; $display("FAIL wr_pulse got=%b exp=00000100", ctrl_we); end
        checks++; if ({bvalid, bresp} !== 3'b100) begin failures++; $display("FAIL wr_bresp got=%b exp=100", {bvalid, bresp}); end
        bready = 1; tick(); bready = 0;
        checks++; if ({bvalid, ctrl_we} !== 9'h0) begin failures++; $display("FAIL wr_after_b got=%h exp=0", {bvalid, ctrl_we}); end
        axi_read(8'h08, d, r, ok);
        checks++; if (!ok || d !== 32'hA5A5_1234 || r !== 2'b00) begin failures++; $display("FAIL rd_word2 got=%h/%b exp=a5a51234/00", d, r); end
    endtask

    task automatic test_w_first();
        awaddr = 8'h00; wdata = 32'h0000_BB00; wstrb = 4'b0010; wvalid = 1; awvalid = 0;
        tick(); wvalid = 0;
        for (int c = 1; c <= 3; c++) begin
            checks++; if ({awready, wready, bvalid} !== 3'b100) begin failures++; $display("FAIL wfirst_cyc%0d got=%b exp=100", c, {awready, wready, bvalid}); end
            if (c == 3) awvalid = 1;
            tick();
        end
        awvalid = 0;
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL wfirst_c4 got=%b exp=0", bvalid); end
        tick();
        checks++; if ({bvalid, bresp, ctrl_we, ctrl_regs[31:0]} !== {3'b100, 8'h01, 32'h0000_BB00}) begin failures++; $display("FAIL wfirst_commit got=%h exp=%h", {bvalid, bresp, ctrl_we, ctrl_regs[31:0]}, {3'b100, 8'h01, 32'h0000_BB00}); end
        bready = 1; tick(); bready = 0;
    endtask

    task automatic test_strobes();
        logic [1:0] r; bit ok; int wc;
        axi_write(8'h00, 32'h1122_3344, 4'hF, r, ok);
        axi_write(8'h00, 32'hAABB_CCDD, 4'b0101, r, ok);
        checks++; if (!ok || r !== 2'b00 || ctrl_regs[31:0] !== 32'h11BB_33DD) begin failures++; $display("FAIL strb_mask got=%h exp=11bb33dd", ctrl_regs[31:0]); end
        wc = we_count;
        axi_write(8'h0C, 32'hFFFF_FFFF, 4'h0, r, ok);
        checks++; if (!ok || r !== 2'b00 || ctrl_regs[127:96] !== 32'h0 || we_count !== wc + 1) begin failures++; $display("FAIL strb_zero got=%h pulses=%0d exp=0 pulses=%0d", ctrl_regs[127:96], we_count - wc, 1); end
    endtask

    task automatic test_illegal();
        logic [255:0] snap; logic [31:0] d; logic [1:0] r; bit ok; int wc;
        snap = ctrl_regs; wc = we_count;
        axi_write(8'h20, 32'h1234_5678, 4'hF, r, ok);
        checks++; if (!ok || r !== 2'b10) begin failures++; $display("FAIL stat_write_resp got=%b exp=10", r); end
        axi_write(8'h3C, 32'h1234_5678, 4'hF, r, ok);
        checks++; if (!ok || r !== 2'b11) begin failures++; $display("FAIL unmap_write_resp got=%b exp=11", r); end
        checks++; if (ctrl_regs !== snap || we_count !== wc) begin failures++; $display("FAIL illegal_side_effect got=%h/%0d exp=%h/%0d", ctrl_regs, we_count, snap, wc); end
        axi_read(8'h3C, d, r, ok);
        checks++; if (!ok || d !== 32'hDEAD_BEEF || r !== 2'b11) begin failures++; $display("FAIL unmap_read got=%h/%b exp=deadbeef/11", d, r); end
        status_regs[31:0] = 32'h0BAD_F00D;
        axi_read(8'h20, d, r, ok);
        checks++; if (!ok || d !== 32'h0BAD_F00D || r !== 2'b00) begin failures++; $display("FAIL stat0_read got=%h/%b exp=0badf00d/00", d, r); end
    endtask

    task automatic test_read_backpressure();
        logic [1:0] r; bit ok;
        axi_write(8'h04, 32'hCAFE_0001, 4'hF, r, ok);
        araddr = 8'h04; arvalid = 1; tick(); arvalid = 0;
        for (int c = 0; c < 10; c++) begin
            checks++; if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b00, 32'hCAFE_0001}) begin failures++; $display("FAIL rd_stall_c%0d got=%b%b/%h exp=10/cafe0001", c, rvalid, arready, rdata); end
            tick();
        end
        rready = 1; tick(); rready = 0;
        checks++; if ({rvalid, arready} !== 2'b01) begin failures++; $display("FAIL rd_release got=%b exp=01", {rvalid, arready}); end
        araddr = 8'h08; arvalid = 1; tick(); arvalid = 0;
        checks++; if ({rvalid, rdata} !== {1'b1, 32'hA5A5_1234}) begin failures++; $display("FAIL rd_second got=%b/%h exp=1/a5a51234", rvalid, rdata); end
        rready = 1; tick(); rready = 0;
    endtask

    task automatic test_read_during_write();
        awaddr = 8'h08; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick(); awvalid = 0; wvalid = 0;
        araddr = 8'h08; arvalid = 1;
        tick(); arvalid = 0;
        checks++; if ({rvalid, rdata, bvalid, ctrl_regs[95:64]} !== {1'b1, 32'hA5A5_1234, 1'b1, 32'h0}) begin failures++; $display("FAIL rd_wr_same got=%h/%h exp=a5a51234/0", rdata, ctrl_regs[95:64]); end
        bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    endtask

    task automatic test_reset_mid();
        int wc;
        awaddr = 8'h14; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick(); awvalid = 0; wvalid = 0; tick();
        araddr = 8'h14; arvalid = 1; tick(); arvalid = 0;
        checks++; if ({bvalid, rvalid, rdata, ctrl_regs[191:160]} !== {2'b11, 32'h55, 32'h55}) begin failures++; $display("FAIL mid_pre got=%b%b/%h exp=11/55", bvalid, rvalid, rdata); end
        rst = 1; tick(); rst = 0;
        checks++; if ({bvalid, rvalid, ctrl_we} !== 10'h0 || ctrl_regs !== 256'h0) begin failures++; $display("FAIL mid_reset got=%b%b we=%h ctrl=%h exp=0", bvalid, rvalid, ctrl_we, ctrl_regs); end
        checks++; if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL mid_ready got=%b exp=111", {awready, wready, arready}); end
        awaddr = 8'h18; awvalid = 1; tick(); awvalid = 0;
        checks++; if ({awready, wready} !== 2'b01) begin failures++; $display("FAIL aw_only got=%b exp=01", {awready, wready}); end
        rst = 1; tick(); rst = 0;
        checks++; if ({awready, wready} !== 2'b11) begin failures++; $display("FAIL aw_discard got=%b exp=11", {awready, wready}); end
        wc = we_count;
        wdata = 32'h77; wvalid = 1; tick(); wvalid = 0;
        repeat (3) tick();
        checks++; if (bvalid !== 1'b0 || ctrl_regs[223:192] !== 32'h0 || we_count !== wc) begin failures++; $display("FAIL w_only got=%b/%h exp=0/0", bvalid, ctrl_regs[223:192]); end
        awaddr = 8'h18; awvalid = 1; tick(); awvalid = 0; tick();
        checks++; if ({bvalid, ctrl_regs[223:192]} !== {1'b1, 32'h77}) begin failures++; $display("FAIL w_then_aw got=%b/%h exp=1/77", bvalid, ctrl_regs[223:192]); end
        bready = 1; tick(); bready = 0;
    endtask

    task automatic test_snapshot();
        logic [31:0] d, exp1; logic [1:0] r; bit ok;
`ifdef AXIL_REG_SNAPSHOT_EN
        exp1 = 32'd2;
`else
        exp1 = 32'd7;
`endif
        status_regs[31:0] = 32'd1; status_regs[63:32] = 32'd2;
        axi_read(8'h20, d, r, ok);
        checks++; if (!ok || d !== 32'd1) begin failures++; $display("FAIL snap_w0 got=%h exp=1", d); end
        status_regs[63:32] = 32'd7;
        axi_read(8'h24, d, r, ok);
        checks++; if (!ok || d !== exp1 || r !== 2'b00) begin failures++; $display("FAIL snap_w1 got=%h exp=%h", d, exp1); end
    endtask

    initial begin
        rst = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = 0; wstrb = 0; status_regs = '0;
        test_reset();
        test_write_aligned();
        test_w_first();
        test_strobes();
        test_illegal();
        test_read_backpressure();
        test_read_during_write();
        test_reset_mid();
        test_snapshot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/s_axil_reg_bank.md
Name: s_axil_reg_bank

Overview:
Parametrised AXI4-Lite slave register file. It is the successor to the fixed-map LED/BRAM-control register block and sits directly on an HPM0_FPD master port in the top level. It provides NUM_CTRL read/write control words with byte strobes and per-word write-strobe pulses, NUM_STAT read-only status words, and SLVERR/DECERR responses for illegal accesses.

Parameters:
DATA_WIDTH, 32, AXI data width; fixed at 32 (byte lanes = 4).
ADDR_WIDTH, 8, byte address bits decoded; must be >= clog2(NUM_CTRL+NUM_STAT)+2.
NUM_CTRL, 8, number of read/write control words.
NUM_STAT, 4, number of read-only status words.
RESET_VAL, 32'h0, reset value of every control word.
DECERR_DATA, 32'hDEADBEEF, rdata returned for unmapped reads.

Ports:
axi_clock  in  1  clock
rst  in  1  synchronous active-high reset
s_axil_awaddr  in  ADDR_WIDTH  write address (byte)
s_axil_awprot  in  3  ignored
s_axil_awvalid / s_axil_awready  in / out  1  AW handshake
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte enables
s_axil_wvalid / s_axil_wready  in / out  1  W handshake
s_axil_bresp  out  2  write response
s_axil_bvalid / s_axil_bready  out / in  1  B handshake
s_axil_araddr  in  ADDR_WIDTH  read address (byte)
s_axil_arprot  in  3  ignored
s_axil_arvalid / s_axil_arready  in / out  1  AR handshake
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid / s_axil_rready  out / in  1  R handshake
ctrl_regs  out  NUM_CTRL*32  control words, word i at [32*i+:32]
ctrl_we  out  NUM_CTRL  one-cycle pulse on commit of word i
status_regs  in  NUM_STAT*32  status words, word j at [32*j+:32]

Behaviour:
- Clocking and reset: one clock, axi_clock. Reset rst is synchronous and active-high.
- Reset values: ctrl_regs=RESET_VAL; ctrl_we=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; awready=wready=arready=1 in the first cycle after reset.
- Decode: idx=addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
  - idx<NUM_CTRL: control word.
  - NUM_CTRL<=idx<NUM_CTRL+NUM_STAT: status word j=idx-NUM_CTRL.
  - Otherwise: unmapped.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, AW and W are accepted independently. awready stays high until AW is captured; wready stays high until W is captured. Either channel may arrive first, or both in the same cycle.
  - The cycle after both are held, the write commits and the FSM enters W_RESP with bvalid=1.
  - Commit to control idx: each byte with wstrb[b]=1 is updated; other bytes hold. ctrl_we[idx]=1 for exactly that cycle, even when wstrb=0. bresp=OKAY (00).
  - Commit to status idx: no state change, no pulse, bresp=SLVERR (10).
  - Commit to unmapped idx: no state change, no pulse, bresp=DECERR (11).
  - In W_RESP, awready=wready=0. bvalid and bresp hold until bready; the FSM returns to W_IDLE on the handshake cycle.
  - Minimum latency: AW+W accepted at edge N gives updated ctrl_regs and bvalid=1 after edge N+1.
- Read FSM, states R_IDLE and R_RESP:
  - arready=1 only in R_IDLE.
  - On the AR handshake at edge N, rdata/rresp are registered and rvalid=1 after edge N; the FSM enters R_RESP.
  - Control read: rdata=current ctrl word, rresp=00.
  - Status read: rdata=status input sampled in the handshake cycle, rresp=00.
  - Unmapped read: rdata=DECERR_DATA, rresp=11.
  - rdata/rresp/rvalid hold until rready; arready returns high the cycle after the R handshake. Maximum read throughput is one read per 2 cycles.
- Simultaneous events:
  - The read and write paths are fully independent.
  - An AR handshake in the same cycle as a write commit to the same word returns the pre-write value.
  - Back-to-back writes: a new AW/W is accepted only after the B handshake.
- Reset mid-operation: partially captured AW/W, pending B and pending R are all discarded. bvalid=rvalid=0, control words return to RESET_VAL, and no ctrl_we pulse is issued.
- Backpressure: stalling bready/rready indefinitely is legal; outputs must stay stable while stalled.

Optional Feature:
Macro: AXIL_REG_SNAPSHOT_EN.
- When defined:
  - A read of status word 0 (idx=NUM_CTRL) captures all NUM_STAT status inputs into a shadow register in the AR handshake cycle and returns word 0 from the capture.
  - Reads of status words 1..NUM_STAT-1 return shadow values, giving coherent multi-word counters.
  - The shadow resets to 0.
- When undefined: no shadow register; every status read samples the live input in its handshake cycle.

Test Plan:
1. Reset, then write idx 2 with wdata=32'hA5A5_1234, wstrb=4'hF, AW and W in the same cycle -> ctrl_regs[95:64]=A5A51234, ctrl_we=8'b0000_0100 for 1 cycle, bresp=00; readback returns A5A51234.
2. W at cycle 0, AW at cycle 3 to idx 0 with wstrb=4'b0010, wdata=32'h0000_BB00, RESET_VAL=0 -> commit at cycle 4, word 0=32'h0000_BB00; awready stays high and wready is low during cycles 1-3.
3. Write to idx NUM_CTRL (status) -> bresp=10, ctrl_regs unchanged, no pulse. Read idx 15 (unmapped, 8+4 map) -> rdata=DEADBEEF, rresp=11.
4. Hold rready=0 for 10 cycles after a read of idx 1 -> rvalid and rdata stable, arready=0 throughout; second AR accepted the cycle after the R handshake.
5. Assert rst while bvalid=1 and an AW is captured -> next cycle bvalid=0, all ctrl words=RESET_VAL, awready=wready=1.
6. With AXIL_REG_SNAPSHOT_EN: status_regs word0=1, word1=2; read word0; change word1 to 7; read word1 -> returns 2. Without the macro the same sequence returns 7.
